// File: rtl/adc_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_filter_pkg
//  Description : Shared types and default constants for the ADC sample
//                filter: FSM state encoding, sample word type, default
//                channel width, averaging exponent and window length.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_filter_pkg;

    localparam int C_DATA_WIDTH = 16;
    localparam int C_AVG_LOG2   = 3;
    localparam int C_DEADBAND   = 4;
    localparam int WINDOW       = 1 << C_AVG_LOG2;

    typedef logic [C_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READ    = 2'd2,
        ST_UPDATE  = 2'd3
    } state_t;

endpackage : adc_filter_pkg
`default_nettype wire

// File: rtl/adc_moving_average.sv
`default_nettype none
// ============================================================================
//  Module      : adc_moving_average
//  Description : One channel of the power-of-2 moving average: capture
//                register, circular sample buffer, running sum and the
//                truncated average. Sequenced by strobes from the top FSM.
//  Ports       : i_clock/i_reset_n  clock, async active-low reset
//                i_load   latch i_data into the capture register
//                i_read   fetch the oldest buffer entry at i_ptr
//                i_write  update running sum, store capture at i_ptr
//                i_filled window full: subtract the oldest entry
//                o_avg    running sum >> AVG_LOG2
//  Revision    : 1.0  initial release
// ============================================================================
module adc_moving_average #(
    parameter int DATA_WIDTH = 16,
    parameter int AVG_LOG2   = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_load,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic                  i_filled,
    input  logic [AVG_LOG2-1:0]   i_ptr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_avg
);
    import adc_filter_pkg::*;

    localparam int SUM_W = DATA_WIDTH + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_sample;
    logic [DATA_WIDTH-1:0] r_oldest;
    logic [SUM_W-1:0]      r_sum;
    logic [SUM_W-1:0]      w_sub;

    // Until the window is full the slot being overwritten never contributed
    // to the sum, so stale buffer contents must not be subtracted.
    always_comb begin
        w_sub = '0;
        if (i_filled) begin
            w_sub = SUM_W'(r_oldest);
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge i_clock) begin
        if (i_write) begin
            r_mem[i_ptr] <= r_sample;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sample <= '0;
            r_oldest <= '0;
            r_sum    <= '0;
        end else begin
            if (i_load) begin
                r_sample <= i_data;
            end
            if (i_read) begin
                r_oldest <= r_mem[i_ptr];
            end
            // The subtracted entry is part of r_sum, so this cannot wrap.
            if (i_write) begin
                r_sum <= r_sum + SUM_W'(r_sample) - w_sub;
            end
        end
    end

    assign o_avg = r_sum[SUM_W-1:AVG_LOG2];

endmodule : adc_moving_average
`default_nettype wire

// File: rtl/adc_sample_filter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_filter
//  Description : Synchronises the SPI receiver frame-done flag, captures both
//                ADC channels and presents a per-channel moving average with
//                a one-cycle valid strobe.
//  Ports       : i_clock, i_reset_n (async active-low)
//                i_data0/i_data1, i_data_received (SPI-domain level flag)
//                o_data0/o_data1 filtered words, o_valid update strobe,
//                o_filled window full (sticky), o_overrun dropped frame (sticky)
//  Config      : ADC_DEADBAND_EN - when defined, an output only changes if
//                the new average differs from it by more than DEADBAND.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_sample_filter
    import adc_filter_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int AVG_LOG2   = C_AVG_LOG2,
    parameter int DEADBAND   = C_DEADBAND
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic                  i_data_received,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic                  o_valid,
    output logic                  o_filled,
    output logic                  o_overrun
);

    localparam logic [AVG_LOG2-1:0] c_last_slot = '1;

    if (AVG_LOG2 < 1 || AVG_LOG2 > 6 || DEADBAND < 0) begin : g_bad_param
        $error("adc_sample_filter: AVG_LOG2 must be 1..6 and DEADBAND >= 0");
    end

    logic                  r_sync1, r_sync2, r_sync3;
    logic                  w_rise;
    state_t                r_state, w_next;
    logic                  w_load, w_read, w_write, w_update;
    logic [AVG_LOG2-1:0]   r_wr_ptr;
    logic [AVG_LOG2-1:0]   r_fill_cnt;
    logic                  r_filled, r_overrun, r_valid;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;
    logic [DATA_WIDTH-1:0] w_avg0, w_avg1;
    logic                  w_upd0, w_upd1;

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_data_received;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_read   = 1'b0;
        w_write  = 1'b0;
        w_update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_load = 1'b1;
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_read = 1'b1;
                w_next = ST_READ;
            end
            ST_READ: begin
                w_write = 1'b1;
                w_next  = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_update = 1'b1;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Write pointer, fill tracking and overrun flag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_filled   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (!r_filled) begin
                    if (r_fill_cnt == c_last_slot) begin
                        r_filled <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
            end
            if (w_rise && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    adc_moving_average #(
        .DATA_WIDTH (DATA_WIDTH),
        .AVG_LOG2   (AVG_LOG2)
    ) u_avg0 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_read    (w_read),
        .i_write   (w_write),
        .i_filled  (r_filled),
        .i_ptr     (r_wr_ptr),
        .i_data    (i_data0),
        .o_avg     (w_avg0)
    );

    adc_moving_average #(
        .DATA_WIDTH (DATA_WIDTH),
        .AVG_LOG2   (AVG_LOG2)
    ) u_avg1 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_read    (w_read),
        .i_write   (w_write),
        .i_filled  (r_filled),
        .i_ptr     (r_wr_ptr),
        .i_data    (i_data1),
        .o_avg     (w_avg1)
    );

`ifdef ADC_DEADBAND_EN
    logic r_primed;

    function automatic logic [DATA_WIDTH-1:0] f_absdiff(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // The first update after the window fills is forced through so the
    // outputs leave their reset value regardless of the deadband.
    always_comb begin
        w_upd0 = !r_primed || (f_absdiff(w_avg0, r_data0) > DATA_WIDTH'(DEADBAND));
        w_upd1 = !r_primed || (f_absdiff(w_avg1, r_data1) > DATA_WIDTH'(DEADBAND));
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_primed <= 1'b0;
        end else if (w_update && r_filled) begin
            r_primed <= 1'b1;
        end
    end
`else
    always_comb begin
        w_upd0 = 1'b1;
        w_upd1 = 1'b1;
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_update && r_filled) begin
                if (w_upd0) begin
                    r_data0 <= w_avg0;
                end
                if (w_upd1) begin
                    r_data1 <= w_avg1;
                end
                r_valid <= w_upd0 | w_upd1;
            end
        end
    end

    assign o_data0   = r_data0;
    assign o_data1   = r_data1;
    assign o_valid   = r_valid;
    assign o_filled  = r_filled;
    assign o_overrun = r_overrun;

endmodule : adc_sample_filter
`default_nettype wire
